tcdm_stream_reader: RTL
=======================

Name: tcdm_stream_reader

Overview:
- Single-port TCDM read master that fetches a strided sequence of 32-bit words and presents them as a valid/ready stream.
- Sits directly upstream of the TCDM memory/interconnect: drives req/add/wen/be/data, consumes gnt/r_data/r_valid.
- Tolerates random grant stalls and downstream backpressure. Used as the load path feeding SNE engines and in TCDM testbenches.

Parameters:
- FIFO_DEPTH, 4, response buffer depth in words; also the maximum of outstanding requests plus buffered words (power of 2, ≥2).
- LEN_W, 16, width of the transfer-length field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush; aborts the transfer
- start_i  in  1  start a transfer; sampled only in IDLE
- base_addr_i  in  32  byte address of the first word
- stride_i  in  32  byte increment between words (two's complement)
- len_i  in  LEN_W  number of words to fetch
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse when the last word is accepted downstream
- tcdm_req_o  out  1  request
- tcdm_gnt_i  in  1  grant
- tcdm_add_o  out  32  byte address
- tcdm_wen_o  out  1  tied 1 (read)
- tcdm_be_o  out  4  tied 4'hF
- tcdm_data_o  out  32  tied 0
- tcdm_r_data_i  in  32  read data
- tcdm_r_valid_i  in  1  read response valid
- stream_data_o  out  32  output word
- stream_valid_o  out  1  output valid
- stream_ready_i  in  1  output ready

Behaviour:
- Reset values: all outputs 0 except tcdm_wen_o=1 and tcdm_be_o=4'hF. The FSM enters IDLE and all counters clear.
- FSM states:
  - IDLE: on start_i with len_i≠0, latch base/stride/len, set addr=base, and go to ISSUE. On start_i with len_i=0, pulse done_o in the next cycle and stay in IDLE.
  - ISSUE: issue requests until issued==len, then go to DRAIN.
  - DRAIN: wait until all responses are received and the FIFO is empty with the last word accepted, then pulse done_o and go to IDLE.
- busy_o=1 in ISSUE and DRAIN.
- Request rule:
  - tcdm_req_o=1 in ISSUE when outstanding + fifo_count < FIFO_DEPTH (credit check).
  - Once asserted, req and add stay stable until a cycle with req&gnt, even if the credit condition would drop. Credits are checked only when raising req.
- Handshake: a request is accepted in a cycle with req&gnt. At that edge: addr += stride (mod 2^32), issued++, outstanding++.
- Response rule:
  - Responses return in order, at least 1 cycle after grant.
  - r_valid pushes r_data into the FIFO and decrements outstanding.
  - Credit accounting guarantees the FIFO never overflows.
  - r_valid with outstanding==0 is ignored; the simulation assertion fires.
- Same-cycle events: grant and r_valid in the same cycle leave outstanding unchanged.
- Stream side:
  - stream_valid_o = FIFO not empty; stream_data_o = FIFO head.
  - Pop on valid&ready. Push and pop in the same cycle are allowed when the FIFO is full.
  - The FIFO is fall-through-free: data reaches the stream no earlier than the cycle after r_valid.
- Counters:
  - issued and accepted are LEN_W wide.
  - outstanding is $clog2(FIFO_DEPTH)+1 bits.
  - done_o fires on the accepted==len transition.
- start_i while busy is ignored.
- clear_i:
  - Next cycle: IDLE, FIFO empty, counters zero, req deasserted, no done_o.
  - Responses still in flight afterwards are discarded: a drop counter is loaded with the current outstanding and absorbs them.
- Reset mid-operation: immediate return to reset values. Any in-flight response is the interconnect's concern.

Decomposition:
- Package sne_tcdm_pkg holds:
  - tcdm_req_t {req, add, wen, be, data} and tcdm_rsp_t {gnt, r_data, r_valid};
  - the state enum {IDLE, ISSUE, DRAIN};
  - constant TCDM_BE_ALL=4'hF.
- One sub-module, tcdm_stream_fifo: a synchronous FIFO with count output, parameterised on DEPTH and DATA_W, with clear.

Test Plan:
- base=0x100, stride=4, len=8, gnt always 1, ready always 1, 1-cycle memory latency:
  - addresses 0x100..0x11C, one per cycle;
  - data equals the preloaded words in order;
  - done_o pulses once; busy_o falls the same cycle.
- Same transfer with 50% random gnt stalls: add is held stable during every stall, no word is lost or duplicated, and 8 words are delivered in order.
- ready=0 for 20 cycles with len=10, FIFO_DEPTH=4: req drops after 4 issued words, outstanding+count never exceeds 4, and all 10 words are delivered after ready rises.
- stride=-4 (0xFFFFFFFC), base=0x8, len=4: addresses 0x8, 0x4, 0x0, 0xFFFFFFFC, wrapping with no error.
- len=0 start: no tcdm_req_o, done_o pulses 1 cycle after start, busy_o stays 0.
- clear_i asserted after 3 of 8 words are granted with 1 response pending:
  - next cycle: IDLE, stream_valid_o=0, the late r_valid is discarded;
  - a new start (base=0x200, len=2) delivers exactly the 2 correct words.

Source files
------------

// File: rtl/sne_tcdm_pkg.sv
// Shared types and constants for the TCDM stream reader: bus bundles,
// FSM state encoding and the fixed byte-enable.
package sne_tcdm_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_rsp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] TCDM_BE_ALL = 4'hF;

endpackage

// File: rtl/tcdm_stream_reader_if.sv
// TCDM read port plus output stream of the reader. Handshakes: a TCDM request
// transfers in any cycle with req&gnt; a stream word transfers on valid&ready.
interface tcdm_stream_reader_if;
  logic        tcdm_req_o;
  logic        tcdm_gnt_i;
  logic [31:0] tcdm_add_o;
  logic        tcdm_wen_o;
  logic [3:0]  tcdm_be_o;
  logic [31:0] tcdm_data_o;
  logic [31:0] tcdm_r_data_i;
  logic        tcdm_r_valid_i;
  logic [31:0] stream_data_o;
  logic        stream_valid_o;
  logic        stream_ready_i;

  modport master (
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
    output stream_data_o, stream_valid_o,
    input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i, stream_ready_i
  );

  modport slave (
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
    input  stream_data_o, stream_valid_o,
    output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i, stream_ready_i
  );
endinterface

// File: rtl/tcdm_stream_fifo.sv
// Registered-output synchronous FIFO with occupancy count and flush.
// A word pushed in cycle N is visible at the head no earlier than cycle N+1.
module tcdm_stream_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // When full, a push is only taken if a pop frees the slot in the same cycle.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/tcdm_stream_reader.sv
// Strided TCDM read master: issues credit-limited read requests and returns
// the responses in order on a valid/ready stream through a small FIFO.
module tcdm_stream_reader
  import sne_tcdm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      stride_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output state_e           state_o,
  tcdm_stream_reader_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DROP_W = CNT_W + 1;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]   len_q, len_d, issued_q, issued_d, accepted_q, accepted_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               hold_q, hold_d, done_q, done_d;

  tcdm_req_t          req_s;
  tcdm_rsp_t          rsp_s;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_sum;
  logic [31:0]        fifo_data;
  logic               fifo_empty, fifo_push, fifo_pop;
  logic               req, fire, rsp_live, rsp_drop;

  assign rsp_s = '{gnt: bus.tcdm_gnt_i, r_data: bus.tcdm_r_data_i, r_valid: bus.tcdm_r_valid_i};

  // Credits are only consulted when raising req; a pending req is held to its grant.
  assign credit_sum = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req       = (state_q == ISSUE) && (hold_q || (credit_sum < (CNT_W+1)'(FIFO_DEPTH)));
  assign fire      = req && rsp_s.gnt;

  // Responses owed to a flushed transfer arrive first and are swallowed.
  assign rsp_drop  = rsp_s.r_valid && (drop_q != '0);
  assign rsp_live  = rsp_s.r_valid && (drop_q == '0) && (outstanding_q != '0);
  assign fifo_push = rsp_live && !clear_i;
  assign fifo_pop  = bus.stream_ready_i && !fifo_empty;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    len_d         = len_q;
    issued_d      = issued_q;
    accepted_d    = accepted_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    hold_d        = 1'b0;
    done_d        = 1'b0;

    if (fire && !rsp_live)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!fire && rsp_live) outstanding_d = outstanding_q - CNT_W'(1);
    if (rsp_drop) drop_d = drop_q - DROP_W'(1);
    if (fifo_pop) accepted_d = accepted_q + LEN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d    = ISSUE;
            addr_d     = base_addr_i;
            stride_d   = stride_i;
            len_d      = len_i;
            issued_d   = '0;
            accepted_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        hold_d = req && !rsp_s.gnt;
        if (fire) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + LEN_W'(1);
          if (issued_q + LEN_W'(1) == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && (accepted_q + LEN_W'(1) == len_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      // Everything still owed by the interconnect, including a grant taken this cycle.
      drop_d        = drop_d + DROP_W'(outstanding_d);
      outstanding_d = '0;
      state_d       = IDLE;
      issued_d      = '0;
      accepted_d    = '0;
      hold_d        = 1'b0;
      done_d        = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      accepted_q    <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      hold_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      accepted_q    <= accepted_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      hold_q        <= hold_d;
      done_q        <= done_d;
    end
  end

  tcdm_stream_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (rsp_s.r_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign req_s = '{req: req, add: addr_q, wen: 1'b1, be: TCDM_BE_ALL, data: 32'h0};

  assign bus.tcdm_req_o     = req_s.req;
  assign bus.tcdm_add_o     = req_s.add;
  assign bus.tcdm_wen_o     = req_s.wen;
  assign bus.tcdm_be_o      = req_s.be;
  assign bus.tcdm_data_o    = req_s.data;
  assign bus.stream_data_o  = fifo_data;
  assign bus.stream_valid_o = !fifo_empty;

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign state_o = state_q;

  // A response nobody asked for is an interconnect protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_s.r_valid && (drop_q == '0) && (outstanding_q == '0)));

endmodule
